// File: rtl/spi_master_gen.sv
// spi_master_gen: SPI master that sends one word of 1..DATA_W bits to one of
// NUM_SS slaves. It supports CPOL/CPHA modes 0-3, MSB- or LSB-first order, a
// programmable half-period and a sticky, maskable completion interrupt.
//
// Ports:
//   clk_cpu, rst      system clock (rising edge); asynchronous active-high reset
//   SPI_BITRATE       SCK half-period minus 1, in clk_cpu cycles
//   SPI_DATA_OUT      word to transmit
//   SPI_LEN           transfer length minus 1 (clamped to DATA_W bits)
//   SPI_SS_SEL        index of the target slave
//   SPI_CTRL          [0]EN [1]START [2]CPOL [3]CPHA [4]LSB_FIRST [5]IRQ_EN [6]IRQ_CLR
//   SPI_DATA_IN       received word, right-aligned, updated only at completion
//   SPI_BUSY          high during SETUP/XFER/HOLD
//   SCK, MOSI, MISO   serial pins
//   SS                active-low slave selects
//   IRQ_SPI           sticky completion interrupt
module spi_master_gen #(
  parameter int DATA_W = 32,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 16
) (
  input  logic                      clk_cpu,
  input  logic                      rst,
  input  logic [DIV_W-1:0]          SPI_BITRATE,
  input  logic [DATA_W-1:0]         SPI_DATA_OUT,
  input  logic [$clog2(DATA_W)-1:0] SPI_LEN,
  input  logic [$clog2(NUM_SS)-1:0] SPI_SS_SEL,
  input  logic [6:0]                SPI_CTRL,
  output logic [DATA_W-1:0]         SPI_DATA_IN,
  output logic                      SPI_BUSY,
  output logic                      SCK,
  output logic                      MOSI,
  input  logic                      MISO,
  output logic [NUM_SS-1:0]         SS,
  output logic                      IRQ_SPI
);
  localparam int LW  = $clog2(DATA_W);
  localparam int LW1 = LW + 1;
  localparam int SW  = $clog2(NUM_SS);
  localparam logic [LW:0] C_DATA_W = LW1'(DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_DONE} state_t;

  // Next bit to put on MOSI, and the shift that exposes the following one.
  function automatic logic f_head(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] f_shift(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  state_t              r_state, w_next;
  logic                r_start_d;
  logic [DIV_W-1:0]    r_cnt, r_div;
  logic [LW:0]         r_hcnt, r_last_hc, r_pad;
  logic                r_sck, r_mosi, r_irq;
  logic                r_cpol, r_cpha, r_lsb;
  logic [SW-1:0]       r_sel;
  logic [DATA_W-1:0]   r_tx, r_rx, r_data_in;

  logic                w_en, w_cpol_in, w_cpha_in, w_lsb_in, w_irq_en, w_irq_clr;
  logic                w_start, w_abort, w_tick, w_sample, w_edge;
  logic [LW:0]         w_n, w_pad_in, w_last_hc;
  logic [DATA_W-1:0]   w_tx_aligned;

  assign w_en      = SPI_CTRL[0];
  assign w_cpol_in = SPI_CTRL[2];
  assign w_cpha_in = SPI_CTRL[3];
  assign w_lsb_in  = SPI_CTRL[4];
  assign w_irq_en  = SPI_CTRL[5];
  assign w_irq_clr = SPI_CTRL[6];

  assign w_start = SPI_CTRL[1] & ~r_start_d & w_en & (r_state == S_IDLE);
  assign w_abort = ~w_en & (r_state != S_IDLE);
  assign w_tick  = (r_cnt == '0);

  // N = LEN+1, clamped to DATA_W; the last half-period index is 2N-1.
  // The doubling may wrap to zero at N = DATA_W; the -1 then yields all ones,
  // which is exactly 2*DATA_W-1.
  assign w_n       = (SPI_LEN >= LW'(DATA_W - 1)) ? C_DATA_W : ({1'b0, SPI_LEN} + LW1'(1));
  assign w_pad_in  = C_DATA_W - w_n;
  assign w_last_hc = (w_n << 1) - LW1'(1);

  // MSB-first words are left-justified so the head bit is always DATA_W-1.
  assign w_tx_aligned = w_lsb_in ? SPI_DATA_OUT : (SPI_DATA_OUT << w_pad_in);

  // Odd edges (even r_hcnt) sample in CPHA=0, even edges sample in CPHA=1.
  assign w_sample = (r_hcnt[0] == r_cpha);
  assign w_edge   = (r_state == S_XFER) & w_tick & ~w_abort;

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_start) w_next = S_SETUP;
        S_SETUP: if (w_tick) w_next = S_XFER;
        S_XFER:  if (w_tick && (r_hcnt == r_last_hc)) w_next = S_HOLD;
        S_HOLD:  if (w_tick) w_next = S_DONE;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_cpu or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Control path: timing counters, pin registers, result and interrupt.
  always_ff @(posedge clk_cpu or posedge rst) begin
    if (rst) begin
      r_start_d <= 1'b0;
      r_cnt     <= '0;
      r_hcnt    <= '0;
      r_sck     <= 1'b0;
      r_mosi    <= 1'b0;
      r_irq     <= 1'b0;
      r_data_in <= '0;
    end else begin
      r_start_d <= SPI_CTRL[1];
      if (w_abort) begin
        r_sck <= r_cpol;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_sck <= w_cpol_in;
            if (w_start) begin
              r_cnt  <= SPI_BITRATE;
              r_hcnt <= '0;
              if (!w_cpha_in) r_mosi <= f_head(w_tx_aligned, w_lsb_in);
            end
          end
          S_SETUP, S_HOLD: r_cnt <= w_tick ? r_div : (r_cnt - DIV_W'(1));
          S_XFER: begin
            if (w_tick) begin
              r_cnt  <= r_div;
              r_sck  <= ~r_sck;
              r_hcnt <= r_hcnt + LW1'(1);
              if (!w_sample) r_mosi <= f_head(r_tx, r_lsb);
            end else begin
              r_cnt <= r_cnt - DIV_W'(1);
            end
          end
          S_DONE: r_data_in <= r_lsb ? (r_rx >> r_pad) : r_rx;
          default: ;
        endcase
      end
      // Completion set has priority over clear and over a same-cycle start.
      if ((r_state == S_DONE) && !w_abort && w_irq_en) begin
        r_irq <= 1'b1;
      end else if (w_irq_clr || w_start) begin
        r_irq <= 1'b0;
      end
    end
  end

  // Data path: transfer configuration and shift registers, latched at start.
  always_ff @(posedge clk_cpu) begin
    if (w_start) begin
      r_div     <= SPI_BITRATE;
      r_pad     <= w_pad_in;
      r_last_hc <= w_last_hc;
      r_cpol    <= w_cpol_in;
      r_cpha    <= w_cpha_in;
      r_lsb     <= w_lsb_in;
      r_sel     <= SPI_SS_SEL;
      r_rx      <= '0;
      // In CPHA=0 the first bit leaves during SETUP, so skip past it here.
      r_tx      <= w_cpha_in ? w_tx_aligned : f_shift(w_tx_aligned, w_lsb_in);
    end else if (w_edge) begin
      if (w_sample) begin
        // LSB-first fills from the top and is right-aligned at completion.
        r_rx <= r_lsb ? {MISO, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], MISO};
      end else begin
        r_tx <= f_shift(r_tx, r_lsb);
      end
    end
  end

  assign SPI_BUSY    = (r_state == S_SETUP) || (r_state == S_XFER) || (r_state == S_HOLD);
  assign SS          = SPI_BUSY ? ~(NUM_SS'(1) << r_sel) : '1;
  assign SCK         = r_sck;
  assign MOSI        = r_mosi;
  assign IRQ_SPI     = r_irq;
  assign SPI_DATA_IN = r_data_in;

endmodule

// File: doc/spi_master_gen.md
Name: spi_master_gen

Overview:
- Parametrised successor to the single-channel SPI master logic. Serialises a variable-length word (1..DATA_W bits) to one of NUM_SS slaves.
- Supports all four CPOL/CPHA modes, MSB- or LSB-first ordering, a programmable bit-rate divider and a sticky, maskable completion interrupt.
- Sits between the CPU register bank (BITRATE/DATA/CTRL registers) and the SPI pins.

Parameters:
- DATA_W, 32, maximum transfer length in bits and width of the data ports.
- NUM_SS, 4, number of active-low slave-select lines.
- DIV_W, 16, width of the bit-rate divider.

Ports:
- clk_cpu  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- SPI_BITRATE  in  DIV_W  SCK half-period minus 1, counted in clk_cpu cycles.
- SPI_DATA_OUT  in  DATA_W  word to transmit.
- SPI_LEN  in  $clog2(DATA_W)  transfer length minus 1.
- SPI_SS_SEL  in  $clog2(NUM_SS)  index of the target slave.
- SPI_CTRL  in  7  [0]EN [1]START [2]CPOL [3]CPHA [4]LSB_FIRST [5]IRQ_EN [6]IRQ_CLR.
- SPI_DATA_IN  out  DATA_W  received word, right-aligned.
- SPI_BUSY  out  1  high while a transfer is in progress.
- SCK  out  1  serial clock.
- MOSI  out  1  serial data to the slave.
- MISO  in  1  serial data from the slave.
- SS  out  NUM_SS  active-low slave selects.
- IRQ_SPI  out  1  completion interrupt; level, sticky.

Behaviour:
- Reset values: SCK=0, MOSI=0, SS=all 1, IRQ_SPI=0, SPI_BUSY=0, SPI_DATA_IN=0, state=IDLE.
- Half period: H = SPI_BITRATE+1 clk_cpu cycles. SPI_BITRATE=0 gives H=1.
- Transfer length: N = SPI_LEN+1. A value of SPI_LEN at or above DATA_W-1 clamps N to DATA_W.
- Start condition: a rising edge of START (registered edge detect) while EN=1 and state=IDLE.
  - On start, the block latches DATA_OUT, N, CPOL, CPHA, LSB_FIRST, H and SS_SEL. Later input changes do not affect the running transfer.
  - START while BUSY is ignored. A START edge in the same cycle EN rises is accepted.
- States:
  - IDLE: SCK tracks the CPOL input, registered with one cycle of lag. SS is all 1.
  - SETUP: SS[sel]=0 and BUSY=1, for H cycles. MOSI presents the first bit if CPHA=0.
  - XFER: 2N half-periods. SCK toggles at the end of each half-period.
    - CPHA=0: sample MISO on odd edges, shift MOSI on even edges.
    - CPHA=1: shift MOSI on odd edges, sample MISO on even edges.
  - HOLD: SCK=CPOL, SS[sel] stays 0 for H cycles.
  - DONE (1 cycle): SS all 1, BUSY=0, SPI_DATA_IN updated, IRQ set if IRQ_EN. Then return to IDLE.
- Bit order:
  - MSB-first: transmit DATA_OUT[N-1] down to [0]. The first bit received lands at DATA_IN[N-1].
  - LSB-first: transmit [0] up to [N-1]. The first bit received lands at DATA_IN[0].
  - DATA_IN bits at index N and above are 0.
- SPI_DATA_IN changes only in DONE and holds its value otherwise.
- Total latency from the start-edge cycle to DONE: H + 2N·H + H cycles, plus 1 for edge detect.
- IRQ_SPI:
  - Cleared by IRQ_CLR=1 or by an accepted start.
  - If set and clear occur in the same cycle, set wins.
  - IRQ_EN=0 suppresses the set but does not clear a pending IRQ.
- Abort: EN=0 in any non-IDLE state.
  - Next cycle: state=IDLE, SS all 1, SCK=CPOL, BUSY=0.
  - No IRQ is raised and DATA_IN is unchanged.
- Reset mid-transfer: all outputs return asynchronously to their reset values.

Test Plan:
- Loopback timing: BITRATE=1, LEN=7, mode 0, MSB-first, DATA_OUT=0xA5, MISO tied to MOSI.
  - DATA_IN=0x000000A5.
  - BUSY high for exactly 36 cycles.
  - 8 SCK rising edges; SS[0] is the only select low.
  - IRQ_SPI=1 after DONE.
- Modes: all four CPOL/CPHA combinations with a model slave returning 0x3C, LEN=7, BITRATE=0.
  - DATA_IN=0x3C in every mode.
  - Idle SCK level equals CPOL.
  - MOSI is stable across every sampling edge.
- Length, order and select: LSB_FIRST=1, LEN=31, DATA_OUT=0x80000001, SS_SEL=3, loopback.
  - DATA_IN=0x80000001.
  - MOSI sequence starts 1,0,0,…; SS=4'b0111.
  - LEN=0 transfers exactly 1 bit.
- Interrupt control:
  - IRQ_EN=0 transfer → IRQ_SPI stays 0.
  - With IRQ pending, IRQ_CLR pulse → IRQ_SPI=0 next cycle.
  - IRQ_CLR asserted in the DONE cycle → IRQ_SPI=1.
- Abort and ignore:
  - EN dropped mid-XFER → SS all 1 and BUSY=0 next cycle; DATA_IN keeps its old value; no IRQ.
  - A second START while busy is ignored: exactly one transfer occurs.
- Reset mid-transfer: assert rst during XFER.
  - SS=all 1, SCK=0, DATA_IN=0 immediately, without waiting for a clock edge.
